// File: rtl/enigma_rotor_controller.sv
// Enigma sequencing controller: time-multiplexes one external letter_shifter
// across three rotor passes, then steps the rotors odometer-style.
module enigma_rotor_controller (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_char,
  input  logic       in_encrypt,
  input  logic       load_en,
  input  logic [6:0] load_r0,
  input  logic [6:0] load_r1,
  input  logic [6:0] load_r2,
  output logic [6:0] sh_char,
  output logic [6:0] sh_rotor,
  output logic       sh_encrypt,
  input  logic [6:0] sh_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_char,
  output logic [6:0] rotor0,
  output logic [6:0] rotor1,
  output logic [6:0] rotor2,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS0 = 3'd1,
    ST_PASS1 = 3'd2,
    ST_PASS2 = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_work;
  logic       r_mode;
  logic       r_letter;
  logic [6:0] r_rotor0;
  logic [6:0] r_rotor1;
  logic [6:0] r_rotor2;

  logic       w_accept;
  logic       w_load;
  logic       w_out_hs;
  logic       w_in_pass;
  logic       w_r0_wrap;
  logic       w_r1_wrap;

  function automatic logic [6:0] inc26(input logic [6:0] v);
    if (v >= 7'd25) begin
      return 7'd0;
    end else begin
      return v + 7'd1;
    end
  endfunction

  // Out-of-range start positions collapse to 0 rather than being reduced mod 26.
  function automatic logic [6:0] clamp_pos(input logic [6:0] v);
    if (v >= 7'd26) begin
      return 7'd0;
    end else begin
      return v;
    end
  endfunction

  assign w_r0_wrap = (r_rotor0 == 7'd25);
  assign w_r1_wrap = (r_rotor1 == 7'd25);
  assign w_in_pass = (r_state == ST_PASS0) || (r_state == ST_PASS1) ||
                     (r_state == ST_PASS2);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_en) begin
          w_load = 1'b1;
        end else if (in_valid) begin
          w_accept = 1'b1;
          if (in_char <= 7'd25) begin
            w_state_nxt = ST_PASS0;
          end else begin
            w_state_nxt = ST_OUT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PASS0: w_state_nxt = ST_PASS1;
      ST_PASS1: w_state_nxt = ST_PASS2;
      ST_PASS2: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_out_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decrypt walks the rotors in reverse order so the inverse undoes each pass.
  always_comb begin
    sh_char    = 7'd0;
    sh_rotor   = 7'd0;
    sh_encrypt = 1'b0;
    case (r_state)
      ST_PASS0: begin
        sh_char    = r_work;
        sh_encrypt = r_mode;
        sh_rotor   = r_mode ? r_rotor0 : r_rotor2;
      end
      ST_PASS1: begin
        sh_char    = r_work;
        sh_encrypt = r_mode;
        sh_rotor   = r_rotor1;
      end
      ST_PASS2: begin
        sh_char    = r_work;
        sh_encrypt = r_mode;
        sh_rotor   = r_mode ? r_rotor2 : r_rotor0;
      end
      default: begin
        sh_char    = 7'd0;
        sh_rotor   = 7'd0;
        sh_encrypt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_work   <= 7'd0;
      r_mode   <= 1'b0;
      r_letter <= 1'b0;
    end else if (w_accept) begin
      r_work   <= in_char;
      r_mode   <= in_encrypt;
      r_letter <= (in_char <= 7'd25);
    end else if (w_in_pass) begin
      r_work   <= sh_result;
    end else begin
      r_work   <= r_work;
    end
  end

  // Rotors move only on a load in IDLE or on the output handshake of a letter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rotor0 <= 7'd0;
      r_rotor1 <= 7'd0;
      r_rotor2 <= 7'd0;
    end else if (w_load) begin
      r_rotor0 <= clamp_pos(load_r0);
      r_rotor1 <= clamp_pos(load_r1);
      r_rotor2 <= clamp_pos(load_r2);
    end else if (w_out_hs && r_letter) begin
      r_rotor0 <= inc26(r_rotor0);
      if (w_r0_wrap) begin
        r_rotor1 <= inc26(r_rotor1);
      end
      if (w_r0_wrap && w_r1_wrap) begin
        r_rotor2 <= inc26(r_rotor2);
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !load_en;
  assign out_valid = (r_state == ST_OUT);
  assign out_char  = r_work;
  assign busy      = (r_state != ST_IDLE);
  assign rotor0    = r_rotor0;
  assign rotor1    = r_rotor1;
  assign rotor2    = r_rotor2;

endmodule

// File: tb/tb_enigma_rotor_controller.sv
// Scoreboard bench for enigma_rotor_controller with a behavioural letter_shifter
// and an odometer-as-integer reference model.
module tb_enigma_rotor_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_char;
  logic       in_encrypt;
  logic       load_en;
  logic [6:0] load_r0, load_r1, load_r2;
  logic [6:0] sh_char, sh_rotor;
  logic       sh_encrypt;
  logic [6:0] sh_result;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_char;
  logic [6:0] rotor0, rotor1, rotor2;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int mr[3];
  int exp_q[$];
  int mon_exp;

  always #5 clk = ~clk;

  enigma_rotor_controller dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_encrypt(in_encrypt), .load_en(load_en),
    .load_r0(load_r0), .load_r1(load_r1), .load_r2(load_r2),
    .sh_char(sh_char), .sh_rotor(sh_rotor), .sh_encrypt(sh_encrypt),
    .sh_result(sh_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .rotor0(rotor0), .rotor1(rotor1), .rotor2(rotor2),
    .busy(busy)
  );

  function automatic logic [6:0] shift_fn(input logic [6:0] c, input logic [6:0] r, input logic e);
    int v;
    if (e) v = int'(c) + int'(r);
    else   v = int'(c) - int'(r) + 26;
    return 7'(v % 26);
  endfunction

  assign sh_result = shift_fn(sh_char, sh_rotor, sh_encrypt);

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_char(input int c, input bit enc);
    int s;
    s = mr[0] + mr[1] + mr[2];
    if (c > 25) return c;
    if (enc) return (c + s) % 26;
    return ((c - s) % 26 + 26) % 26;
  endfunction

  // Rotors viewed as a 3-digit base-26 counter.
  task automatic model_step();
    int n;
    n = mr[0] + 26 * mr[1] + 676 * mr[2];
    n = (n + 1) % 17576;
    mr[0] = n % 26;
    mr[1] = (n / 26) % 26;
    mr[2] = n / 676;
  endtask

  task automatic check_rotors(input string tag);
    chk({tag, "_rotor0"}, int'(rotor0), mr[0]);
    chk({tag, "_rotor1"}, int'(rotor1), mr[1]);
    chk({tag, "_rotor2"}, int'(rotor2), mr[2]);
  endtask

  // Monitor: pops the scoreboard whenever an output handshake is about to happen.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", int'(out_char), -1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_char", int'(out_char), mon_exp);
      end
    end
  end

  task automatic do_load(input int a, input int b, input int c);
    load_en = 1'b1;
    load_r0 = 7'(a);
    load_r1 = 7'(b);
    load_r2 = 7'(c);
    @(negedge clk);
    chk("in_ready_during_load", int'(in_ready), 0);
    @(posedge clk); #1;
    load_en = 1'b0;
    mr[0] = (a >= 26) ? 0 : a;
    mr[1] = (b >= 26) ? 0 : b;
    mr[2] = (c >= 26) ? 0 : c;
    @(negedge clk);
    check_rotors("load");
    @(posedge clk); #1;
  endtask

  task automatic send(input int c, input bit enc, input int hold);
    int  n;
    int  lat;
    int  ex;
    bit  letter;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 0, 1);
    letter = (c <= 25);
    ex = model_char(c, enc);
    exp_q.push_back(ex);
    in_valid   = 1'b1;
    in_char    = 7'(c);
    in_encrypt = enc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_char  = 7'($urandom_range(0, 127));
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, letter ? 4 : 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_char", int'(out_char), ex);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_busy", int'(busy), 1);
      check_rotors("hold");
      @(posedge clk); #1;
      load_en = h[0];
      load_r0 = 7'($urandom_range(0, 25));
      load_r1 = 7'($urandom_range(0, 25));
      load_r2 = 7'($urandom_range(0, 25));
    end
    load_en   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (letter) model_step();
    @(negedge clk);
    chk("post_hs_out_valid", int'(out_valid), 0);
    chk("post_hs_busy", int'(busy), 0);
    check_rotors("post_hs");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_char = 7'd0; in_encrypt = 1'b0;
    load_en = 1'b0; load_r0 = 7'd0; load_r1 = 7'd0; load_r2 = 7'd0;
    out_ready = 1'b0;
    mr[0] = 0; mr[1] = 0; mr[2] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sh_char", int'(sh_char), 0);
    check_rotors("rst");
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);

    send(0, 1'b1, 0);
    do_load(3, 5, 7);
    send(2, 1'b1, 0);
    do_load(3, 5, 7);
    send(17, 1'b0, 0);
    do_load(25, 25, 25);
    send(1, 1'b1, 0);
    do_load(25, 24, 0);
    send(5, 1'b1, 0);
    send(3, 1'b1, 5);
    send(30, 1'b1, 0);
    do_load(40, 2, 26);

    // Reset while the character sits in PASS1.
    do_load(3, 5, 7);
    in_valid = 1'b1; in_char = 7'd4; in_encrypt = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pass1_sh_rotor", int'(sh_rotor), 5);
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sh_char", int'(sh_char), 0);
    mr[0] = 0; mr[1] = 0; mr[2] = 0;
    check_rotors("midrst");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    send(7, 1'b1, 1);

    for (int i = 0; i < 40; i++) begin
      int c;
      if ($urandom_range(0, 3) == 0)
        do_load($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
      if ($urandom_range(0, 4) == 0) c = $urandom_range(26, 127);
      else                           c = $urandom_range(0, 25);
      send(c, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_controller.md
# enigma_rotor_controller

Sequencing controller for the Enigma datapath. It accepts one character at a time over a valid/ready handshake and time-multiplexes a single external `letter_shifter` instance across three rotor passes. It returns the enciphered or deciphered character over an output handshake, then steps the three rotor positions odometer-style. It sits between the keyboard/character source and the display/output buffer.

## Interface
Parameters:
- none. Rotor count is fixed at 3; alphabet size is fixed at 26.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_char`/`in_encrypt` are valid.
- `in_ready`  out  1  controller can accept a character.
- `in_char`  in  7  character code; 0..25 = 'A'..'Z'.
- `in_encrypt`  in  1  1 = encrypt (add shifts), 0 = decrypt (subtract shifts).
- `load_en`  in  1  load rotor start positions (honoured only in IDLE).
- `load_r0`, `load_r1`, `load_r2`  in  7 each  rotor start positions.
- `sh_char`  out  7  character operand to `letter_shifter`.
- `sh_rotor`  out  7  rotor shift operand to `letter_shifter`.
- `sh_encrypt`  out  1  mode to `letter_shifter`.
- `sh_result`  in  7  combinational result from `letter_shifter` (0..25).
- `out_valid`  out  1  `out_char` is valid.
- `out_ready`  in  1  consumer accepts `out_char`.
- `out_char`  out  7  processed character.
- `rotor0`, `rotor1`, `rotor2`  out  7 each  current rotor positions (0..25), for display.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PASS0, PASS1, PASS2, OUT.
- Registers: work char (7b), mode (1b), rotor0..2 (7b), state.
- IDLE:
  - `in_ready = ~load_en`.
  - If `load_en`: each `load_rN` ≥ 26 loads as 0; otherwise it loads as given. Any input is not accepted that cycle.
  - Else, on `in_valid & in_ready`: latch `in_char` and `in_encrypt`.
  - If `in_char` ≤ 25, go to PASS0. If `in_char` ≥ 26 (non-letter), go to OUT with work char = `in_char` (bypass).
- PASSk:
  - Drive `sh_char` = work char, `sh_encrypt` = mode, and `sh_rotor` = selected rotor.
  - Rotor selection: encrypt uses rotor0, rotor1, rotor2 for PASS0, PASS1, PASS2. Decrypt uses rotor2, rotor1, rotor0.
  - At the edge, work char ← `sh_result`. PASS0→PASS1→PASS2→OUT unconditionally.
- Outside PASS states, `sh_char`, `sh_rotor` and `sh_encrypt` are driven 0.
- OUT:
  - `out_valid` = 1 and `out_char` = work char, both held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
  - Step the rotors at that edge only if the character was a letter:
    - rotor0 ← (rotor0+1) mod 26.
    - If rotor0 was 25, rotor1 ← (rotor1+1) mod 26.
    - If rotor0 and rotor1 were both 25, rotor2 ← (rotor2+1) mod 26.
- Net transform: encrypt gives c + r0 + r1 + r2 mod 26; decrypt gives c − (r0 + r1 + r2) mod 26. Decrypt from the same start positions recovers the plaintext because stepping is identical in both modes.
- `load_en` and `in_valid` outside IDLE are ignored.

## Timing
- Reset (async assert, sync release) forces:
  - state = IDLE.
  - Rotors = 0 and work char = 0.
  - `out_valid` = 0, `busy` = 0, `sh_*` = 0.
  - `in_ready` = 1 once `resetn` is high and `load_en` is low.
  - An in-flight character is dropped.
- Letter latency: accept edge E0; PASS0/1/2 occupy cycles E0→E1, E1→E2, E2→E3. `out_valid` rises after E3, so accept-to-`out_valid` is 4 cycles.
- Non-letter latency: `out_valid` rises after E1 (1 cycle).
- Throughput: one character per 5 cycles when `out_ready` is held high.
- A new character can be accepted one cycle after the output handshake, because `in_ready` is asserted only in IDLE.
- Rotor outputs change only at the output handshake edge or a load edge.
- `letter_shifter` is purely combinational and must settle within one cycle.

## Test plan
- Reset, rotors (0,0,0), encrypt char 0 -> `out_char`=0, 4 cycles after accept; rotors (1,0,0) after handshake.
- Load (3,5,7), encrypt char 2 -> `out_char`=17, rotors (4,5,7). Reload (3,5,7), decrypt 17 -> 2.
- Load (25,25,25), encrypt char 1 -> `out_char`=24; rotors step to (0,0,0). Load (25,24,0) -> step gives (0,25,0).
- Hold `out_ready`=0 for 5 cycles -> `out_char` stable, `in_ready`=0, rotors unchanged, `load_en` pulses ignored.
- Encrypt char 30 -> `out_char`=30 one cycle after accept, rotors unchanged. Load (40,2,26) -> rotors (0,2,0).
- Assert `resetn`=0 during PASS1 -> immediately IDLE, `out_valid`=0, rotors 0. The next character is processed normally.
